// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MIPS data memory: access sizes,
// controller states, lane-enable mask and alignment check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Little-endian byte lanes touched by an access of size sz at offset a.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    m = 4'h0;
    case (sz)
      SZ_BYTE: m = 4'b0001 << a;
      SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~a[0];
      SZ_WORD: ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_memory_sized_load_align.sv
// Load lane select plus zero/sign extension of a 32-bit memory word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  // Word loads ignore sign_ext; illegal sizes never reach read_data.
  always_comb begin
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte/half/word data memory updated on the falling edge, with an optional
// post-reset zeroing sweep during which busy is high and requests are dropped.
module data_memory_sized
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 15,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              fault,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  logic [3:0][7:0]  r_mem [DEPTH];
  state_e           r_state;
  logic [IDX_W-1:0] r_clr_cnt;
  logic [31:0]      r_read_data;
  logic             r_read_valid;
  logic             r_fault;

  logic             w_idle;
  logic             w_req;
  logic             w_ok;
  logic             w_store;
  logic             w_load;
  logic             w_fault;
  logic             w_sweep;
  logic [IDX_W-1:0] w_widx;
  logic [IDX_W-1:0] w_ridx;
  logic [3:0]       w_we;
  logic [31:0]      w_wdata;
  logic [31:0]      w_store_data;
  logic [31:0]      w_rword;
  logic [31:0]      w_ldata;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_req   = memwrite | memread;
  assign w_ok    = is_aligned(size, address[1:0]);
  assign w_store = w_idle & memwrite & w_ok;
  assign w_load  = w_idle & memread & ~memwrite & w_ok;
  assign w_fault = w_idle & w_req & ~w_ok;
  assign w_sweep = (r_state == ST_INIT) & CLEAR_ON_RESET & rst_n;

  always_comb begin
    w_store_data = write_data;
    case (size)
      SZ_BYTE: w_store_data = {4{write_data[7:0]}};
      SZ_HALF: w_store_data = {2{write_data[15:0]}};
      default: w_store_data = write_data;
    endcase
  end

  // The sweep and stores share one write port; they are mutually exclusive by state.
  assign w_widx  = w_sweep ? r_clr_cnt : address[ADDR_W-1:2];
  assign w_we    = w_sweep ? 4'hF : (w_store ? lane_mask(size, address[1:0]) : 4'h0);
  assign w_wdata = w_sweep ? 32'h0 : w_store_data;
  assign w_ridx  = address[ADDR_W-1:2];
  assign w_rword = r_mem[w_ridx];

  always_ff @(negedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_we[l]) r_mem[w_widx][l] <= w_wdata[l*8 +: 8];
    end
  end

  load_align u_load_align (
    .i_word     (w_rword),
    .i_size     (size),
    .i_addr_lo  (address[1:0]),
    .i_sign_ext (sign_ext),
    .o_data     (w_ldata)
  );

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_clr_cnt    <= '0;
      r_read_data  <= 32'h0;
      r_read_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (CLEAR_ON_RESET) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST_IDX) r_state <= ST_IDLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      r_read_valid <= w_load;
      r_fault      <= w_fault;
      if (w_load) r_read_data <= w_ldata;
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign fault      = r_fault;
  assign busy       = (r_state == ST_INIT);

endmodule
